// File: rtl/aes_sbox_array_if.sv
// Valid/ready bundle for the AES byte-substitution unit: input side carries the
// bytes, direction and tag; output side returns the substituted word with them.
interface aes_sbox_array_if #(
  parameter int LANES = 4,
  parameter int TAG_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_inv;
  logic [TAG_W-1:0]     in_tag;
  logic [8*LANES-1:0]   in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_inv;
  logic [TAG_W-1:0]     out_tag;
  logic [8*LANES-1:0]   out_data;

  modport master (
    output in_valid, in_inv, in_tag, in_data, out_ready,
    input  in_ready, out_valid, out_inv, out_tag, out_data
  );

  modport slave (
    input  in_valid, in_inv, in_tag, in_data, out_ready,
    output in_ready, out_valid, out_inv, out_tag, out_data
  );
endinterface

// File: rtl/aes_sbox_array.sv
// Pipelined AES SubBytes / InvSubBytes over LANES bytes with full back-pressure.
// Direction and tag travel with each transfer, so enc/dec traffic can interleave freely.
module aes_sbox_array #(
  parameter int LANES  = 4,
  parameter int STAGES = 1,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  aes_sbox_array_if.slave   bus
);

  if (STAGES < 1 || STAGES > 2) begin : g_bad_stages
    $error("aes_sbox_array: STAGES must be 1 or 2");
  end
  if (LANES < 1 || LANES > 16) begin : g_bad_lanes
    $error("aes_sbox_array: LANES must be in 1..16");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("aes_sbox_array: TAG_W must be at least 1");
  end

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8); it maps 0 to 0 as AES requires
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = x;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] y);
    logic [7:0] b;
    b = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  // Constant-argument tables; synthesis folds each entry to a literal ROM word
  logic [7:0] fwd_rom [256];
  logic [7:0] inv_rom [256];

  for (genvar g = 0; g < 256; g++) begin : g_rom
    assign fwd_rom[g] = sbox_fwd(8'(g));
    assign inv_rom[g] = sbox_inv(8'(g));
  end

  logic [8*LANES-1:0] sub_data;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] lane_byte;
    assign lane_byte            = bus.in_data[8*l +: 8];
    assign sub_data[8*l +: 8]   = bus.in_inv ? inv_rom[lane_byte] : fwd_rom[lane_byte];
  end

  logic               take1;
  logic               push;
  logic               s1_valid_q;
  logic               s1_valid_d;
  logic               s1_inv_q;
  logic [TAG_W-1:0]   s1_tag_q;
  logic [8*LANES-1:0] s1_data_q;

  assign bus.in_ready = rst_n & take1;
  assign push         = bus.in_valid & bus.in_ready;
  assign s1_valid_d   = take1 ? push : s1_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_inv_q   <= 1'b0;
      s1_tag_q   <= '0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (push) begin
        s1_inv_q  <= bus.in_inv;
        s1_tag_q  <= bus.in_tag;
        s1_data_q <= sub_data;
      end
    end
  end

  if (STAGES == 2) begin : g_two
    logic               take2;
    logic               s2_valid_q;
    logic               s2_valid_d;
    logic               s2_inv_q;
    logic [TAG_W-1:0]   s2_tag_q;
    logic [8*LANES-1:0] s2_data_q;

    assign take2      = !s2_valid_q | bus.out_ready;
    assign take1      = !s1_valid_q | take2;
    assign s2_valid_d = take2 ? s1_valid_q : s2_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid_q <= 1'b0;
        s2_inv_q   <= 1'b0;
        s2_tag_q   <= '0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s2_valid_d;
        if (take2 && s1_valid_q) begin
          s2_inv_q  <= s1_inv_q;
          s2_tag_q  <= s1_tag_q;
          s2_data_q <= s1_data_q;
        end
      end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.out_inv   = s2_inv_q;
    assign bus.out_tag   = s2_tag_q;
    assign bus.out_data  = s2_data_q;
  end else begin : g_one
    assign take1         = !s1_valid_q | bus.out_ready;
    assign bus.out_valid = s1_valid_q;
    assign bus.out_inv   = s1_inv_q;
    assign bus.out_tag   = s1_tag_q;
    assign bus.out_data  = s1_data_q;
  end

endmodule
